// File: rtl/clmul_birimi.sv
// clmul_birimi: iterative carry-less (GF(2)) multiplier with clmul/clmulh/clmulr modes.
// Consumes ADIM_BIT multiplier bits per cycle; valid/ready on both sides, flushable.
module clmul_birimi #(
  parameter int VERI_GENISLIGI = 32,
  parameter int ADIM_BIT       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      gecerli_i,
  output logic                      hazir_o,
  input  logic [VERI_GENISLIGI-1:0] sayi1_i,
  input  logic [VERI_GENISLIGI-1:0] sayi2_i,
  input  logic [1:0]                islem_i,
  input  logic                      iptal_i,
  output logic                      gecerli_o,
  input  logic                      hazir_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o
);

  localparam int W  = VERI_GENISLIGI;
  localparam int N  = W / ADIM_BIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets where the step size does not tile the operand width.
  generate
    if (W < 2 || ADIM_BIT < 1 || (W % ADIM_BIT) != 0) begin : g_paramCheck
      $error("clmul_birimi: ADIM_BIT must divide VERI_GENISLIGI and width must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    BOSTA   = 2'b00,
    HESAPLA = 2'b01,
    SONUC   = 2'b10
  } durum_t;

  durum_t          r_durum;
  durum_t          w_sonrakiDurum;
  logic [2*W-1:0]  r_a2;
  logic [W-1:0]    r_b;
  logic [1:0]      r_islem;
  logic [2*W-1:0]  r_acc;
  logic [CW-1:0]   r_sayac;
  logic            r_gecerli;
  logic [W-1:0]    r_sonuc;
  logic [2*W-1:0]  w_kismi;
  logic [2*W-1:0]  w_accSonraki;
  logic [W-1:0]    w_secilen;
  logic            w_kabul;
  logic            w_sonAdim;

  assign w_kabul   = gecerli_i & hazir_o;
  assign w_sonAdim = (r_durum == HESAPLA) && (r_sayac == CW'(N - 1));

  // XOR together the shifted multiplicand for every set bit in this step's multiplier slice.
  // r_a2 already carries the counter*ADIM_BIT offset, so only the in-step offset j is added here.
  always_comb begin
    w_kismi = '0;
    for (int j = 0; j < ADIM_BIT; j++) begin
      if (r_b[j]) begin
        w_kismi = w_kismi ^ (r_a2 << j);
      end
    end
    w_accSonraki = r_acc ^ w_kismi;
  end

  // Pick the result window from the product that the final step produces.
  always_comb begin
    case (r_islem)
      2'b01:   w_secilen = w_accSonraki[2*W-1:W];
      2'b10:   w_secilen = w_accSonraki[2*W-2:W-1];
      default: w_secilen = w_accSonraki[W-1:0];
    endcase
  end

  // State register; reset dominates everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_sonrakiDurum;
    end
  end

  // Next-state logic; a flush returns to idle from any state, ahead of accept or handoff.
  always_comb begin
    w_sonrakiDurum = r_durum;
    if (iptal_i) begin
      w_sonrakiDurum = BOSTA;
    end else begin
      case (r_durum)
        BOSTA:   if (w_kabul) w_sonrakiDurum = HESAPLA;
        HESAPLA: if (w_sonAdim) w_sonrakiDurum = SONUC;
        SONUC:   if (hazir_i) w_sonrakiDurum = BOSTA;
        default: w_sonrakiDurum = BOSTA;
      endcase
    end
  end

  // Outputs: ready only when idle and not being reset or flushed; result side is registered.
  always_comb begin
    hazir_o   = (r_durum == BOSTA) && !rst_i && !iptal_i;
    gecerli_o = r_gecerli;
    sonuc_o   = r_sonuc;
  end

  // Datapath: latch operands on accept, accumulate one slice per step, publish on the last step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a2      <= '0;
      r_b       <= '0;
      r_islem   <= '0;
      r_acc     <= '0;
      r_sayac   <= '0;
      r_gecerli <= 1'b0;
      r_sonuc   <= '0;
    end else if (iptal_i) begin
      r_acc     <= '0;
      r_sayac   <= '0;
      r_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (w_kabul) begin
            r_a2    <= {{W{1'b0}}, sayi1_i};
            r_b     <= sayi2_i;
            r_islem <= islem_i;
            r_acc   <= '0;
            r_sayac <= '0;
          end
        end
        HESAPLA: begin
          r_acc   <= w_accSonraki;
          r_a2    <= r_a2 << ADIM_BIT;
          r_b     <= r_b >> ADIM_BIT;
          r_sayac <= r_sayac + CW'(1);
          if (w_sonAdim) begin
            r_sonuc   <= w_secilen;
            r_gecerli <= 1'b1;
          end
        end
        SONUC: begin
          if (hazir_i) r_gecerli <= 1'b0;
        end
        default: r_gecerli <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_birimi.sv
// tb_clmul_birimi: scoreboard bench driving three clmul_birimi instances
// (ADIM_BIT = 4, 1, 32) in lockstep with shared handshake and control inputs.
module tb_clmul_birimi;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] acceptCyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gecerliIn = 1'b0;
  logic [31:0] sayi1 = '0;
  logic [31:0] sayi2 = '0;
  logic [1:0]  islem = '0;
  logic        iptal = 1'b0;
  logic        hazirIn = 1'b1;
  logic [2:0]  hazirOut;
  logic [2:0]  gOut;
  logic [31:0] sOut [3];

  int          latN [3] = '{8, 32, 1};
  exp_t        scoreQ [3][$];
  logic [2:0]  seen = '0;
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Edge counter used to time-stamp accepts and results.
  always @(posedge clk) cyc <= cyc + 1;

  clmul_birimi #(.VERI_GENISLIGI(W), .ADIM_BIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .gecerli_i(gecerliIn), .hazir_o(hazirOut[0]),
    .sayi1_i(sayi1), .sayi2_i(sayi2), .islem_i(islem), .iptal_i(iptal),
    .gecerli_o(gOut[0]), .hazir_i(hazirIn), .sonuc_o(sOut[0]));

  clmul_birimi #(.VERI_GENISLIGI(W), .ADIM_BIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .gecerli_i(gecerliIn), .hazir_o(hazirOut[1]),
    .sayi1_i(sayi1), .sayi2_i(sayi2), .islem_i(islem), .iptal_i(iptal),
    .gecerli_o(gOut[1]), .hazir_i(hazirIn), .sonuc_o(sOut[1]));

  clmul_birimi #(.VERI_GENISLIGI(W), .ADIM_BIT(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .gecerli_i(gecerliIn), .hazir_o(hazirOut[2]),
    .sayi1_i(sayi1), .sayi2_i(sayi2), .islem_i(islem), .iptal_i(iptal),
    .gecerli_o(gOut[2]), .hazir_i(hazirIn), .sonuc_o(sOut[2]));

  // Bit-serial golden model: build the 64-bit product one multiplier bit at a time.
  function automatic logic [31:0] goldClmul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'h0, a} << i);
    end
    case (op)
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return p[31:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: on the first cycle each instance shows a result, pop and compare value and latency.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (gOut[i] && !seen[i]) begin
        seen[i] = 1'b1;
        if (scoreQ[i].size() == 0) begin
          checkOutput($sformatf("unexpected_result_inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = scoreQ[i].pop_front();
          checkOutput($sformatf("result_inst%0d", i), sOut[i], e.val);
          checkOutput($sformatf("latency_inst%0d", i), 32'(cyc) - e.acceptCyc, 32'(latN[i]));
        end
      end
      if (!gOut[i]) seen[i] = 1'b0;
    end
  end

  // Offer one operation to all instances once every one is ready; push expectations per mask.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               input logic [31:0] expected, input logic [2:0] mask);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (hazirOut != 3'b111 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (hazirOut != 3'b111) begin
      checkOutput("ready_timeout", {29'h0, hazirOut}, 32'h7);
    end
    sayi1     = a;
    sayi2     = b;
    islem     = op;
    gecerliIn = 1'b1;
    e.val       = expected;
    e.acceptCyc = 32'(cyc + 1);
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) scoreQ[i].push_back(e);
    end
    @(posedge clk);
    #1;
    gecerliIn = 1'b0;
    sayi1     = $urandom;
    sayi2     = $urandom;
    islem     = 2'($urandom_range(0, 3));
  endtask

  // Wait until every expected result has been handed off and all instances are idle.
  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((scoreQ[0].size() + scoreQ[1].size() + scoreQ[2].size() != 0 ||
            hazirOut != 3'b111) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle_drain", 32'(scoreQ[0].size() + scoreQ[1].size() + scoreQ[2].size()), 32'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    int guard;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;

    // Reset behaviour
    @(negedge clk);
    #1;
    checkOutput("hazir_during_reset", {29'h0, hazirOut}, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("gecerli_after_reset", {29'h0, gOut}, 32'h0);
    checkOutput("sonuc_after_reset", sOut[0], 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("hazir_after_reset", {29'h0, hazirOut}, 32'h7);

    // Directed vectors
    applyStimulus(32'h3, 32'h3, 2'b00, 32'h5, 3'b111);
    applyStimulus(32'h3, 32'h3, 2'b01, 32'h0, 3'b111);
    applyStimulus(32'h3, 32'h3, 2'b10, 32'h0, 3'b111);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 3'b111);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 3'b111);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 3'b111);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555, 3'b111);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h5555_5555, 3'b111);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hAAAA_AAAA, 3'b111);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h5555_5555, 3'b111);
    applyStimulus(32'h0, 32'h1234_5678, 2'b00, 32'h0, 3'b111);
    waitIdle();

    // Backpressure on the ADIM_BIT=4 instance
    hazirIn = 1'b0;
    applyStimulus(32'h3, 32'h3, 2'b00, 32'h5, 3'b111);
    guard = 0;
    while (!gOut[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("bp_rise", {31'h0, gOut[0]}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_gecerli_%0d", k), {31'h0, gOut[0]}, 32'h1);
      checkOutput($sformatf("bp_sonuc_%0d", k), sOut[0], 32'h5);
      checkOutput($sformatf("bp_hazir_%0d", k), {31'h0, hazirOut[0]}, 32'h0);
    end
    hazirIn = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_gecerli", {31'h0, gOut[0]}, 32'h0);
    checkOutput("bp_release_hazir", {31'h0, hazirOut[0]}, 32'h1);
    waitIdle();

    // Flush in the middle of computation; only the single-step instance finishes first.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555, 3'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    iptal = 1'b1;
    #1;
    checkOutput("hazir_during_iptal", {29'h0, hazirOut}, 32'h0);
    @(negedge clk);
    iptal = 1'b0;
    checkOutput("gecerli_after_iptal", {29'h0, gOut}, 32'h0);
    repeat (40) @(negedge clk);
    applyStimulus(32'h3, 32'h3, 2'b00, 32'h5, 3'b111);
    waitIdle();

    // Reset in the middle of computation.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555, 3'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("gecerli_after_midreset", {29'h0, gOut}, 32'h0);
    checkOutput("sonuc4_after_midreset", sOut[0], 32'h0);
    checkOutput("sonuc1_after_midreset", sOut[1], 32'h0);
    checkOutput("sonuc32_after_midreset", sOut[2], 32'h0);
    repeat (40) @(negedge clk);
    applyStimulus(32'h3, 32'h3, 2'b00, 32'h5, 3'b111);
    waitIdle();

    // Random operations against the bit-serial model, all modes.
    for (int n = 0; n < 200; n++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      applyStimulus(a, b, op, goldClmul(a, b, op), 3'b111);
    end
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/clmul_birimi.md
Name: clmul_birimi

Overview:
- Iterative, parameterised carry-less (GF(2) polynomial) multiplier for the execute stage.
- Supports the three Zbc modes:
  - clmul: low half of the product.
  - clmulh: high half of the product.
  - clmulr: reversed window of the product.
- Processes ADIM_BIT multiplier bits per clock, trading latency for area.
- Uses valid/ready handshakes on both sides and supports abort on pipeline flush.

Parameters:
- VERI_GENISLIGI, 32, operand and result width W; must be ≥ 2.
- ADIM_BIT, 4, multiplier bits consumed per compute cycle; must divide W exactly (elaboration-time check).

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- gecerli_i  input  1  an operation is offered.
- hazir_o  output  1  block can accept an operation.
- sayi1_i  input  W  operand a (multiplicand).
- sayi2_i  input  W  operand b (multiplier).
- islem_i  input  2  mode select:
  - 00 = clmul.
  - 01 = clmulh.
  - 10 = clmulr.
  - 11 = treated as clmul.
- iptal_i  input  1  flush; aborts any in-flight operation.
- gecerli_o  output  1  sonuc_o holds a finished result.
- hazir_i  input  1  consumer accepts the result.
- sonuc_o  output  W  registered result.

Behaviour:
- Reset (rst_i high at an edge):
  - State becomes BOSTA and the counter clears.
  - gecerli_o = 0, sonuc_o = 0, internal accumulator = 0.
  - hazir_o is forced 0 while rst_i is high.
- hazir_o = (state == BOSTA) & !rst_i & !iptal_i. It is combinational and has no dependence on gecerli_i.
- Accept: a transfer happens at an edge with gecerli_i & hazir_o. At that edge the block:
  - latches a, b and islem_i;
  - clears the 2W-bit accumulator and sets counter = 0;
  - moves to HESAPLA.
  - Inputs may change freely after the accept edge.
- HESAPLA, one edge per step. For each j in 0..ADIM_BIT-1 where b_reg[j] = 1:
  - acc ^= (a_reg zero-extended to 2W) << (counter*ADIM_BIT + j).
  - Then b_reg >>= ADIM_BIT and counter increments.
  - On the edge that completes step N-1 (N = W/ADIM_BIT), the full product is selected into sonuc_o, gecerli_o is set to 1, and the state moves to SONUC.
- Latency: with the accept at edge k, gecerli_o is high after edge k+N.
  - W=32, ADIM_BIT=4 gives 8 cycles.
  - ADIM_BIT=1 gives 32 cycles.
  - ADIM_BIT=W gives 1 cycle.
- Result selection, on the 2W-bit product P:
  - clmul: P[W-1:0].
  - clmulh: P[2W-1:W]. P[2W-1] is always 0.
  - clmulr: P[2W-2:W-1].
- SONUC:
  - gecerli_o and sonuc_o stay stable until the edge where hazir_i = 1.
  - At that edge gecerli_o goes to 0 and the state returns to BOSTA.
  - No new operation is accepted in the same cycle; hazir_o is 0 in SONUC.
- sonuc_o keeps its last value after the handoff; consumers use it only while gecerli_o = 1.
- iptal_i, at any edge in any state:
  - The next state is BOSTA, gecerli_o = 0, and the partial product is discarded.
  - iptal_i has priority over acceptance and over result handoff.
- Priority order: rst_i > iptal_i > normal transitions.
- Operands of zero need no special case; they still take the full N cycles and produce 0. There is no early termination.
- An unused state encoding recovers to BOSTA on the next edge.

Test Plan:
1. W=32, ADIM_BIT=4: a=0x00000003, b=0x00000003.
   - clmul → 0x00000005.
   - clmulh → 0x00000000.
   - clmulr → 0x00000000.
   - gecerli_o rises exactly 8 edges after accept.
2. a=0x80000000, b=0x80000000.
   - clmul → 0x00000000.
   - clmulh → 0x40000000.
   - clmulr → 0x80000000.
3. a=b=0xFFFFFFFF.
   - clmul → 0x55555555.
   - clmulh → 0x55555555.
   - clmulr → 0xAAAAAAAA.
   - islem_i=11 → 0x55555555.
4. Backpressure: hold hazir_i=0 for 5 cycles after gecerli_o rises → sonuc_o and gecerli_o stable, hazir_o=0 throughout; then hazir_i=1 for one edge → gecerli_o=0 and hazir_o=1 next cycle.
5. Abort and reset during compute:
   - Assert iptal_i during HESAPLA step 3 → gecerli_o never rises; the next accepted op (a=0x3, b=0x3, clmul) returns 0x5 with no leftover terms.
   - Repeat with rst_i in place of iptal_i → sonuc_o=0.
6. Re-instantiate with ADIM_BIT=1 and with ADIM_BIT=32, plus a 200-op random comparison against a bit-serial XOR-shift golden model in all modes → latency of 32 and 1 respectively, and zero mismatches.
